tspi_obi_arbiter: RTL

Sequencing arbiter that shares the single `tspi_host` OBI subordinate port between two requesters: the block-swap controller (`block_swap_ctrl` SD-card port) and the CPU-side transparent-SPI OBI port from the user demux. It replaces the static `block_swap_on`-driven mux in `user_domain`. It holds ownership for a whole SPI session so chip-select framing of a block transfer is never interleaved with CPU accesses. Responses are routed back to the owner only.

---
 rtl/tspi_obi_arbiter.sv | 187 ++++++++++++++++++
 1 files changed

// File: rtl/tspi_obi_arbiter.sv
// Session-holding round-robin arbiter sharing the tspi_host OBI port
// between block-swap and CPU; TSPI_ARB_TIMEOUT_EN adds the idle-release counter.
package tspi_obi_pkg;
  typedef struct packed {
    int unsigned AddrWidth;
    int unsigned DataWidth;
  } obi_cfg_t;

  localparam obi_cfg_t ObiDefaultCfg = '{AddrWidth: 32, DataWidth: 32};

  typedef struct packed {
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic        aid;
  } obi_a_t;

  typedef struct packed {
    logic   req;
    obi_a_t a;
  } obi_req_t;

  typedef struct packed {
    logic [31:0] rdata;
    logic        rid;
    logic        err;
  } obi_r_t;

  typedef struct packed {
    logic   gnt;
    logic   rvalid;
    obi_r_t r;
  } obi_rsp_t;
endpackage

module tspi_obi_arbiter #(
  parameter tspi_obi_pkg::obi_cfg_t ObiCfg = tspi_obi_pkg::ObiDefaultCfg,
  parameter type obi_req_t = tspi_obi_pkg::obi_req_t,
  parameter type obi_rsp_t = tspi_obi_pkg::obi_rsp_t,
  parameter int unsigned IdleTimeout = 16
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       block_swap_on_i,
  input  obi_req_t   swap_obi_req_i,
  output obi_rsp_t   swap_obi_rsp_o,
  input  obi_req_t   cpu_obi_req_i,
  output obi_rsp_t   cpu_obi_rsp_o,
  output obi_req_t   tspi_obi_req_o,
  input  obi_rsp_t   tspi_obi_rsp_i,
  output logic [1:0] owner_o,
  output logic       busy_o
);

  if (IdleTimeout < 1 || $bits(ObiCfg) == 0) begin : g_bad_cfg
    $error("IdleTimeout must be at least 1");
  end

  typedef enum logic [1:0] {IDLE, OWN_SWAP, OWN_CPU} state_e;

  state_e state_q, state_d;
  logic   last_cpu_q, last_cpu_d;
  logic   outstanding_q, outstanding_d;
  logic   own_swap, own_cpu;
  logic   swap_elig, cpu_elig;
  logic   owner_req, fwd_req, hs, rv;
  logic   expired, release_own;

  assign own_swap  = (state_q == OWN_SWAP);
  assign own_cpu   = (state_q == OWN_CPU);
  assign swap_elig = swap_obi_req_i.req & block_swap_on_i;
  assign cpu_elig  = cpu_obi_req_i.req;

  assign owner_req = (own_swap & swap_obi_req_i.req)
                   | (own_cpu & cpu_obi_req_i.req);

  // Only one transaction in flight: mask req while one is pending
  assign fwd_req = ~outstanding_q
                 & ((own_swap & swap_elig) | (own_cpu & cpu_elig));
  assign hs      = fwd_req & tspi_obi_rsp_i.gnt;
  assign rv      = outstanding_q & tspi_obi_rsp_i.rvalid;

  assign outstanding_d = hs
                       | (outstanding_q & ~tspi_obi_rsp_i.rvalid);

  assign release_own = (own_swap | own_cpu)
                     & ~outstanding_q & ~hs
                     & ((~owner_req & expired)
                       | (own_swap & ~block_swap_on_i));

  assign owner_o = {own_cpu, own_swap};
  assign busy_o  = outstanding_q;

`ifdef TSPI_ARB_TIMEOUT_EN
  localparam int unsigned CntW = $clog2(IdleTimeout + 1);
  localparam logic [CntW-1:0] CntMax = CntW'(IdleTimeout);

  logic [CntW-1:0] idle_cnt_q, idle_cnt_d;

  // The cycle carrying rvalid already counts as idle
  always_comb begin
    idle_cnt_d = idle_cnt_q;
    if (state_d != state_q || !(own_swap || own_cpu) ||
        owner_req || hs ||
        (outstanding_q && !tspi_obi_rsp_i.rvalid)) begin
      idle_cnt_d = '0;
    end else if (idle_cnt_q != CntMax) begin
      idle_cnt_d = idle_cnt_q + CntW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      idle_cnt_q <= '0;
    end else begin
      idle_cnt_q <= idle_cnt_d;
    end
  end

  assign expired = (idle_cnt_q == CntMax);
`else
  assign expired = 1'b1;
`endif

  always_comb begin
    state_d    = state_q;
    last_cpu_d = last_cpu_q;
    unique case (state_q)
      IDLE: begin
        if (swap_elig && cpu_elig) begin
          state_d = last_cpu_q ? OWN_SWAP : OWN_CPU;
        end else if (swap_elig) begin
          state_d = OWN_SWAP;
        end else if (cpu_elig) begin
          state_d = OWN_CPU;
        end
      end
      OWN_SWAP: begin
        if (release_own) begin
          state_d    = cpu_elig ? OWN_CPU : IDLE;
          last_cpu_d = 1'b0;
        end
      end
      OWN_CPU: begin
        if (release_own) begin
          state_d    = swap_elig ? OWN_SWAP : IDLE;
          last_cpu_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    tspi_obi_req_o = '0;
    swap_obi_rsp_o = '0;
    cpu_obi_rsp_o  = '0;
    if (own_swap) begin
      tspi_obi_req_o        = swap_obi_req_i;
      tspi_obi_req_o.req    = fwd_req;
      swap_obi_rsp_o.gnt    = hs;
      swap_obi_rsp_o.rvalid = rv;
      swap_obi_rsp_o.r      = tspi_obi_rsp_i.r;
    end
    if (own_cpu) begin
      tspi_obi_req_o       = cpu_obi_req_i;
      tspi_obi_req_o.req   = fwd_req;
      cpu_obi_rsp_o.gnt    = hs;
      cpu_obi_rsp_o.rvalid = rv;
      cpu_obi_rsp_o.r      = tspi_obi_rsp_i.r;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q       <= IDLE;
      last_cpu_q    <= 1'b1;
      outstanding_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      last_cpu_q    <= last_cpu_d;
      outstanding_q <= outstanding_d;
    end
  end

endmodule
